// File: rtl/equihash_stage_sequencer.sv
// Run controller for the Equihash collision core: walks stages 0..LAST_STAGE,
// ping-ponging read/write windows between regions A and B and chaining write ends.
module equihash_stage_sequencer #(
  parameter logic [3:0] LAST_STAGE = 4'h9,
  parameter int         ADDR_W     = 32,
  parameter int         TIMEOUT_W  = 24
) (
  input  logic              eclk,
  input  logic              rst,
  input  logic              run_start,
  input  logic              run_abort,
  input  logic [ADDR_W-1:0] seed_end,
  input  logic [ADDR_W-1:0] region_a_base,
  input  logic [ADDR_W-1:0] region_b_base,
  input  logic [ADDR_W-1:0] region_size,
  output logic [3:0]        stage,
  output logic [ADDR_W-1:0] stage_cxor_base,
  output logic [ADDR_W-1:0] stage_cxor_end,
  output logic [ADDR_W-1:0] stage_nxor_base,
  output logic [ADDR_W-1:0] stage_nxor_limit,
  input  logic [ADDR_W-1:0] stage_nxor_end,
  output logic              collision_start,
  input  logic              collision_done,
  output logic              busy,
  output logic              run_done,
  output logic [1:0]        run_status
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_EMPTY   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  // The watchdog expires on the cycle its count would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~{{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [2:0]           state;
  logic [TIMEOUT_W-1:0] wdog;
  logic [ADDR_W-1:0]    end_q;
  logic                 in_run;
  logic                 finish;
  logic [1:0]           finish_status;

  assign in_run = (state != S_IDLE) && (state != S_DONE);

  // Every way out of a run funnels through finish so DONE entry is handled once.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    finish        = 1'b0;
    finish_status = ST_OK;
    if (run_abort && in_run) begin
      finish        = 1'b1;
      finish_status = ST_ABORT;
    end else if (state == S_WAIT) begin
      if (!collision_done && wdog == WDOG_LAST) begin
        finish        = 1'b1;
        finish_status = ST_TIMEOUT;
      end
    end else if (state == S_CHECK) begin
      if (stage == LAST_STAGE) begin
        finish        = 1'b1;
        finish_status = ST_OK;
      end else if (end_q == stage_nxor_base) begin
        finish        = 1'b1;
        finish_status = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge eclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state            <= S_IDLE;
      wdog             <= '0;
      end_q            <= '0;
      stage            <= 4'd0;
      stage_cxor_base  <= '0;
      stage_cxor_end   <= '0;
      stage_nxor_base  <= '0;
      stage_nxor_limit <= '0;
      collision_start  <= 1'b0;
      busy             <= 1'b0;
      run_done         <= 1'b0;
      run_status       <= ST_OK;
    end else begin
      collision_start <= 1'b0;
      run_done        <= 1'b0;
      if (finish) begin
        state      <= S_DONE;
        busy       <= 1'b0;
        run_done   <= 1'b1;
        run_status <= finish_status;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (run_start) begin
              state            <= S_SETUP;
              busy             <= 1'b1;
              run_status       <= ST_OK;
              stage            <= 4'd0;
              stage_cxor_base  <= region_a_base;
              stage_cxor_end   <= seed_end;
              stage_nxor_base  <= region_b_base;
              stage_nxor_limit <= region_b_base + region_size;
            end
          end
          // Windows were loaded on SETUP entry, so they lead the start pulse by a cycle.
          S_SETUP: begin
            state           <= S_START;
            collision_start <= 1'b1;
          end
          S_START: begin
            state <= S_WAIT;
            wdog  <= '0;
          end
          S_WAIT: begin
            if (collision_done) begin
              end_q <= stage_nxor_end;
              state <= S_CHECK;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_CHECK: begin
            // Swap regions: this stage's output becomes the next stage's input.
            state            <= S_SETUP;
            stage            <= stage + 4'd1;
            stage_cxor_base  <= stage_nxor_base;
            stage_cxor_end   <= end_q - ADDR_W'(1);
            stage_nxor_base  <= stage_cxor_base;
            stage_nxor_limit <= stage_cxor_base + region_size;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_equihash_stage_sequencer.sv
// Directed bench for equihash_stage_sequencer with a small collision-core model
// answering each start pulse with nxor_end = nxor_base + 4 (or an empty result).
module tb_equihash_stage_sequencer;

  localparam int ADDR_W    = 32;
  localparam int TIMEOUT_W = 4;

  logic              eclk;
  logic              rst;
  logic              run_start;
  logic              run_abort;
  logic [ADDR_W-1:0] seed_end;
  logic [ADDR_W-1:0] region_a_base;
  logic [ADDR_W-1:0] region_b_base;
  logic [ADDR_W-1:0] region_size;
  logic [3:0]        stage;
  logic [ADDR_W-1:0] stage_cxor_base;
  logic [ADDR_W-1:0] stage_cxor_end;
  logic [ADDR_W-1:0] stage_nxor_base;
  logic [ADDR_W-1:0] stage_nxor_limit;
  logic [ADDR_W-1:0] stage_nxor_end;
  logic              collision_start;
  logic              collision_done;
  logic              busy;
  logic              run_done;
  logic [1:0]        run_status;

  equihash_stage_sequencer #(
    .LAST_STAGE(4'h9),
    .ADDR_W    (ADDR_W),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .eclk            (eclk),
    .rst             (rst),
    .run_start       (run_start),
    .run_abort       (run_abort),
    .seed_end        (seed_end),
    .region_a_base   (region_a_base),
    .region_b_base   (region_b_base),
    .region_size     (region_size),
    .stage           (stage),
    .stage_cxor_base (stage_cxor_base),
    .stage_cxor_end  (stage_cxor_end),
    .stage_nxor_base (stage_nxor_base),
    .stage_nxor_limit(stage_nxor_limit),
    .stage_nxor_end  (stage_nxor_end),
    .collision_start (collision_start),
    .collision_done  (collision_done),
    .busy            (busy),
    .run_done        (run_done),
    .run_status      (run_status)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Core model controls and observations.
  bit          mute        = 1'b0;
  logic [3:0]  empty_stage = 4'hF;
  int          lat         = 3;
  int          start_count = 0;
  int          start_cyc   = 0;
  int          done_pulses = 0;
  int          cyc         = 0;
  logic [31:0] s1_cb, s1_ce, s1_nb, s1_nl, s0_nl;
  logic [31:0] prev_cb, prev_nb;

  always @(posedge eclk) cyc <= cyc + 1;
  always @(negedge eclk) if (run_done) done_pulses++;

  initial begin
    collision_done = 1'b0;
    stage_nxor_end = '0;
    prev_cb = '0;
    prev_nb = '0;
    forever begin
      @(negedge eclk);
      if (collision_start) begin
        start_count++;
        start_cyc = cyc;
        check("win_cxor_base_hold", stage_cxor_base, prev_cb);
        check("win_nxor_base_hold", stage_nxor_base, prev_nb);
        if (stage == 4'd0) s0_nl = stage_nxor_limit;
        if (stage == 4'd1) begin
          s1_cb = stage_cxor_base;
          s1_ce = stage_cxor_end;
          s1_nb = stage_nxor_base;
          s1_nl = stage_nxor_limit;
        end
        if (!mute) begin
          repeat (lat - 1) @(negedge eclk);
          stage_nxor_end = (stage == empty_stage) ? stage_nxor_base : stage_nxor_base + 32'd4;
          collision_done = 1'b1;
          @(negedge eclk);
          collision_done = 1'b0;
        end
      end
      prev_cb = stage_cxor_base;
      prev_nb = stage_nxor_base;
    end
  end

  task automatic pulse_start();
    run_start = 1'b1;
    @(negedge eclk);
    run_start = 1'b0;
  endtask

  task automatic wait_run_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge eclk);
      if (run_done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_start_at(input string tag, input logic [3:0] stg, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge eclk);
      if (collision_start && stage == stg) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  int base_pulses;

  initial begin
    rst = 1'b1;
    run_start = 1'b0;
    run_abort = 1'b0;
    seed_end      = 32'h0000_000F;
    region_a_base = 32'h0000_0000;
    region_b_base = 32'h0000_0100;
    region_size   = 32'h0000_0100;
    repeat (2) @(negedge eclk);

    check("rst_stage", 32'(stage), 32'd0);
    check("rst_cxor_base", stage_cxor_base, 32'd0);
    check("rst_nxor_limit", stage_nxor_limit, 32'd0);
    check("rst_ctl", {28'd0, collision_start, busy, run_done, 1'b0}, 32'd0);
    check("rst_status", 32'(run_status), 32'd0);
    rst = 1'b0;
    @(negedge eclk);

    // Spurious done in IDLE must do nothing.
    collision_done = 1'b1;
    @(negedge eclk);
    collision_done = 1'b0;
    repeat (3) @(negedge eclk);
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_starts", 32'(start_count), 32'd0);
    check("idle_done_pulses", 32'(done_pulses), 32'd0);

    // Full run with a spurious run_start in the middle.
    start_count = 0;
    base_pulses = done_pulses;
    pulse_start();
    check("run_busy", 32'(busy), 32'd1);
    wait_start_at("full_reach_s2", 4'd2, 100);
    @(negedge eclk);
    pulse_start();
    wait_run_done("full_done", 300);
    check("full_status", 32'(run_status), 32'd0);
    check("full_stage", 32'(stage), 32'd9);
    check("full_busy", 32'(busy), 32'd0);
    check("s0_nxor_limit", s0_nl, 32'h200);
    check("s1_cxor_base", s1_cb, 32'h100);
    check("s1_cxor_end", s1_ce, 32'h103);
    check("s1_nxor_base", s1_nb, 32'h0);
    check("s1_nxor_limit", s1_nl, 32'h100);
    check("s9_cxor_base", stage_cxor_base, 32'h100);
    check("s9_cxor_end", stage_cxor_end, 32'h103);
    check("s9_nxor_base", stage_nxor_base, 32'h0);
    repeat (20) @(negedge eclk);
    check("full_starts", 32'(start_count), 32'd10);
    check("full_one_run", 32'(done_pulses - base_pulses), 32'd1);

    // Empty result at stage 3, restarted straight from DONE.
    empty_stage = 4'd3;
    start_count = 0;
    pulse_start();
    wait_run_done("empty_done", 200);
    check("empty_status", 32'(run_status), 32'd1);
    check("empty_stage", 32'(stage), 32'd3);
    check("empty_nxor_base", stage_nxor_base, 32'h0);
    repeat (10) @(negedge eclk);
    check("empty_starts", 32'(start_count), 32'd4);
    empty_stage = 4'hF;

    // Watchdog: start seen one cycle before WAIT entry, DONE 15 edges after entry.
    mute = 1'b1;
    start_count = 0;
    pulse_start();
    wait_run_done("to_done", 60);
    check("to_latency", 32'(cyc - start_cyc), 32'd16);
    check("to_status", 32'(run_status), 32'd2);
    check("to_stage", 32'(stage), 32'd0);
    check("to_starts", 32'(start_count), 32'd1);
    mute = 1'b0;
    repeat (5) @(negedge eclk);

    // Abort during stage 2 WAIT.
    lat = 6;
    start_count = 0;
    pulse_start();
    wait_start_at("ab_reach_s2", 4'd2, 100);
    @(negedge eclk);
    run_abort = 1'b1;
    @(negedge eclk);
    run_abort = 1'b0;
    check("ab_run_done", 32'(run_done), 32'd1);
    check("ab_status", 32'(run_status), 32'd3);
    check("ab_stage", 32'(stage), 32'd2);
    check("ab_busy", 32'(busy), 32'd0);
    repeat (30) @(negedge eclk);
    check("ab_starts", 32'(start_count), 32'd3);
    lat = 3;

    // Reset during stage 5, then a fresh run from stage 0.
    pulse_start();
    wait_start_at("rr_reach_s5", 4'd5, 200);
    base_pulses = done_pulses;
    rst = 1'b1;
    @(negedge eclk);
    rst = 1'b0;
    check("rr_stage", 32'(stage), 32'd0);
    check("rr_cxor_end", stage_cxor_end, 32'd0);
    check("rr_nxor_base", stage_nxor_base, 32'd0);
    check("rr_ctl", {28'd0, collision_start, busy, run_done, 1'b0}, 32'd0);
    check("rr_status", 32'(run_status), 32'd0);
    repeat (20) @(negedge eclk);
    check("rr_no_done", 32'(done_pulses - base_pulses), 32'd0);
    pulse_start();
    wait_start_at("rr_restart_s0", 4'd0, 20);
    check("rr_restart_cxor", stage_cxor_base, 32'h0);
    wait_run_done("rr_done", 300);
    check("rr_final_status", 32'(run_status), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
